// File: rtl/clockport_pkg.sv
// Shared types and constants for the clockport read-direction data path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clockport_pkg;

  // Default bus width of the clockport data path.
  localparam int CP_DW = 8;

  // Value presented on the bus when a read finds the FIFO empty.
  localparam logic [CP_DW-1:0] CP_IDLE_DATA = 8'hFF;

  // Read-access sequencer states.
  typedef enum logic [1:0] {
    CP_IDLE    = 2'd0,
    CP_DRIVE   = 2'd1,
    CP_RELEASE = 2'd2
  } cp_state_t;

endpackage

// File: rtl/cp_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit strobe.
// Latency: 2 clk from input change to q.
// Backpressure: none; free-running.
// Ports: clk, rst_n (sync, active-low), d (async in), q (synchronised out).
module cp_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clockport_read_port.sv
// Pi-side byte FIFO drained one byte per Amiga clockport read access.
// Latency: strobe edge to cp_oe_n change 3 clk; push visible in pi_level after 1 clk.
// Backpressure: pi_full advertises a full FIFO; pushes while full are dropped and flagged.
// Ports: clk, rst_n; Pi side pi_data/pi_wr/pi_full/pi_level/pi_overflow;
//        clockport side cp_cs_n/cp_rd_n (async) -> cp_d/cp_oe_n/cp_underrun; clr_flags.
module clockport_read_port
  import clockport_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = CP_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW-1:0]          pi_data,
  input  logic                   pi_wr,
  output logic                   pi_full,
  output logic [$clog2(DEPTH):0] pi_level,
  output logic                   pi_overflow,
  input  logic                   cp_cs_n,
  input  logic                   cp_rd_n,
  output logic [DW-1:0]          cp_d,
  output logic                   cp_oe_n,
  output logic                   cp_underrun,
  input  logic                   clr_flags
);

  localparam int             AW        = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_L   = (AW + 1)'(DEPTH);
  localparam logic [DW-1:0]  IDLE_DATA = DW'(CP_IDLE_DATA);

  // Strobe synchronisers
  logic cs_sync;
  logic rd_sync;
  logic access;

  cp_sync2 #(.RST_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cp_cs_n),
    .q     (cs_sync)
  );

  cp_sync2 #(.RST_VAL(1'b1)) u_sync_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cp_rd_n),
    .q     (rd_sync)
  );

  assign access = !cs_sync && !rd_sync;

  // FIFO: extra pointer MSB separates full from empty.
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   level;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  cp_state_t state;
  // Set when the current access found the FIFO empty; such an access must
  // not consume a byte that arrives while it is being driven.
  logic      started_empty;

  assign level      = wr_ptr - rd_ptr;
  assign fifo_full  = (level == DEPTH_L);
  assign fifo_empty = (level == '0);
  assign push       = pi_wr && !fifo_full;
  assign pop        = (state == CP_DRIVE) && !access && !started_empty;

  assign pi_full  = fifo_full;
  assign pi_level = level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= pi_data;
  end

  // Read-access sequencer with registered bus outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= CP_IDLE;
      cp_oe_n       <= 1'b1;
      cp_d          <= IDLE_DATA;
      started_empty <= 1'b0;
    end else begin
      unique case (state)
        CP_IDLE: begin
          cp_oe_n <= 1'b1;
          if (access) begin
            state         <= CP_DRIVE;
            cp_oe_n       <= 1'b0;
            started_empty <= fifo_empty;
            cp_d          <= fifo_empty ? IDLE_DATA : mem[rd_ptr[AW-1:0]];
          end
        end
        CP_DRIVE: begin
          if (!access) begin
            state   <= CP_RELEASE;
            cp_oe_n <= 1'b1;
          end
        end
        CP_RELEASE: begin
          // One-clk gap guarantees each access pops exactly once.
          state   <= CP_IDLE;
          cp_oe_n <= 1'b1;
        end
        default: begin
          state   <= CP_IDLE;
          cp_oe_n <= 1'b1;
        end
      endcase
    end
  end

  // Sticky flags; a same-cycle set wins over clr_flags.
  logic overflow_set;
  logic underrun_set;

  assign overflow_set = pi_wr && fifo_full;
  assign underrun_set = (state == CP_IDLE) && access && fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pi_overflow <= 1'b0;
      cp_underrun <= 1'b0;
    end else begin
      if (overflow_set)   pi_overflow <= 1'b1;
      else if (clr_flags) pi_overflow <= 1'b0;
      if (underrun_set)   cp_underrun <= 1'b1;
      else if (clr_flags) cp_underrun <= 1'b0;
    end
  end

endmodule
